// File: rtl/memc_multiport.sv
// memc_multiport: round-robin arbiter that moves single read/write requests
// from NUM_PORTS requestors onto one single-port block RAM.
// Each accepted request walks IDLE -> ISSUE -> (WAIT) -> RESP.
// Out-of-range addresses follow the same timing but never strobe the RAM.
module memc_multiport #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DEPTH  = 65536,
  parameter int RD_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             req_valid,
  input  logic [NUM_PORTS-1:0]             req_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]             req_ready,
  output logic [NUM_PORTS-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             busy,
  output logic                             bram_rd_enable,
  output logic                             bram_wr_enable,
  output logic [ADDR_WIDTH-1:0]            bram_addr,
  output logic [DATA_WIDTH-1:0]            bram_wr_data,
  input  logic [DATA_WIDTH-1:0]            bram_rd_data
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [PW-1:0] LAST_GRANT_RST = PW'(NUM_PORTS - 1);
  localparam logic [CW-1:0] CNT_LAST       = CW'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e                  state_q;
  logic [PW-1:0]           port_q;
  logic                    we_q;
  logic                    oor_q;
  logic [CW-1:0]           cnt_q;
  logic [PW-1:0]           last_grant_q;
  logic [NUM_PORTS-1:0]    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    rsp_err_q;
  logic                    busy_q;
  logic                    bram_rd_enable_q;
  logic                    bram_wr_enable_q;
  logic [ADDR_WIDTH-1:0]   bram_addr_q;
  logic [DATA_WIDTH-1:0]   bram_wr_data_q;

  logic                    grant_hit;
  logic [PW-1:0]           grant_idx;
  logic [PW-1:0]           cand_idx;
  logic                    sel_we;
  logic                    sel_oor;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  // Address is outside the implemented RAM words.
  function automatic logic addr_oor(input logic [ADDR_WIDTH-1:0] a);
    return (64'(a) >= 64'(MEM_DEPTH));
  endfunction

  // One-hot completion vector for a port number.
  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [PW-1:0] p);
    logic [NUM_PORTS-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  // Round-robin search starting one past the last granted port.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand_idx = PW'((int'(last_grant_q) + 1 + i) % NUM_PORTS);
      if (!grant_hit && req_valid[cand_idx]) begin
        grant_hit = 1'b1;
        grant_idx = cand_idx;
      end else begin
        grant_hit = grant_hit;
      end
    end
  end

  // Payload of the port the arbiter picked.
  always_comb begin
    sel_we    = req_we[grant_idx];
    sel_addr  = req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    sel_wdata = req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    sel_oor   = addr_oor(sel_addr);
  end

  // Grant is combinational so the requestor sees it in the accept cycle; held low in reset.
  always_comb begin
    req_ready = '0;
    if (reset && (state_q == IDLE) && grant_hit) begin
      req_ready[grant_idx] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Controller FSM with all datapath outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      port_q           <= '0;
      we_q             <= 1'b0;
      oor_q            <= 1'b0;
      cnt_q            <= '0;
      last_grant_q     <= LAST_GRANT_RST;
      rsp_valid_q      <= '0;
      rsp_rdata_q      <= '0;
      rsp_err_q        <= 1'b0;
      busy_q           <= 1'b0;
      bram_rd_enable_q <= 1'b0;
      bram_wr_enable_q <= 1'b0;
      bram_addr_q      <= '0;
      bram_wr_data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          rsp_valid_q <= '0;
          rsp_err_q   <= 1'b0;
          if (grant_hit) begin
            port_q           <= grant_idx;
            we_q             <= sel_we;
            oor_q            <= sel_oor;
            last_grant_q     <= grant_idx;
            busy_q           <= 1'b1;
            bram_addr_q      <= sel_addr;
            bram_wr_data_q   <= sel_wdata;
            bram_wr_enable_q <= sel_we & ~sel_oor;
            bram_rd_enable_q <= ~sel_we & ~sel_oor;
            state_q          <= ISSUE;
          end else begin
            bram_wr_enable_q <= 1'b0;
            bram_rd_enable_q <= 1'b0;
            busy_q           <= 1'b0;
            state_q          <= IDLE;
          end
        end
        ISSUE: begin
          bram_wr_enable_q <= 1'b0;
          bram_rd_enable_q <= 1'b0;
          cnt_q            <= '0;
          if (we_q) begin
            rsp_valid_q <= port_onehot(port_q);
            rsp_err_q   <= oor_q;
            state_q     <= RESP;
          end else begin
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == CNT_LAST) begin
            rsp_rdata_q <= oor_q ? '0 : bram_rd_data;
            rsp_valid_q <= port_onehot(port_q);
            rsp_err_q   <= oor_q;
            state_q     <= RESP;
          end else begin
            cnt_q       <= cnt_q + CW'(1);
            state_q     <= WAIT;
          end
        end
        RESP: begin
          rsp_valid_q <= '0;
          rsp_err_q   <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          rsp_valid_q      <= '0;
          rsp_err_q        <= 1'b0;
          busy_q           <= 1'b0;
          bram_wr_enable_q <= 1'b0;
          bram_rd_enable_q <= 1'b0;
          state_q          <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err        = rsp_err_q;
  assign busy           = busy_q;
  assign bram_rd_enable = bram_rd_enable_q;
  assign bram_wr_enable = bram_wr_enable_q;
  assign bram_addr      = bram_addr_q;
  assign bram_wr_data   = bram_wr_data_q;

endmodule

// File: tb/tb_memc_multiport.sv
// Bench for memc_multiport: two instances (4 ports each).
// Instance 0: MEM_DEPTH=1024, RD_LATENCY=1. Instance 1: MEM_DEPTH=65536, RD_LATENCY=3.
// Expected responses are queued on accept and compared when the DUT responds.
module tb_memc_multiport;
  localparam int NI = 2;
  localparam int NP = 4;

  typedef struct {
    int         inst;
    int         port;
    logic [7:0] rdata;
    logic       err;
    longint     due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n [NI];
  logic [NP-1:0]    req_valid_s [NI];
  logic [NP-1:0]    req_we_s    [NI];
  logic [NP*16-1:0] req_addr_s  [NI];
  logic [NP*8-1:0]  req_wdata_s [NI];
  logic [NP-1:0]    req_ready_s [NI];
  logic [NP-1:0]    rsp_valid_s [NI];
  logic [7:0]       rsp_rdata_s [NI];
  logic             rsp_err_s   [NI];
  logic             busy_s      [NI];
  logic             rd_en_s     [NI];
  logic             wr_en_s     [NI];
  logic [15:0]      bram_addr_s [NI];
  logic [7:0]       bram_wd_s   [NI];

  bit [7:0] ram_m  [NI][65536];
  bit [7:0] ref_m  [NI][65536];
  bit [7:0] pipe_m [NI][4];

  exp_t       sb_q [$];
  int         grant_log [$];
  longint     str_cyc   [NI];
  logic       str_rd    [NI];
  logic       str_wr    [NI];
  logic [15:0] str_addr [NI];
  logic [7:0]  str_wd   [NI];
  longint     busy_from [NI];
  longint     busy_to   [NI];
  logic [7:0] last_rd   [NI];
  longint     cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  memc_multiport #(.NUM_PORTS(NP), .DATA_WIDTH(8), .ADDR_WIDTH(16),
                   .MEM_DEPTH(1024), .RD_LATENCY(1)) u_dut0 (
    .clk(clk), .reset(rst_n[0]),
    .req_valid(req_valid_s[0]), .req_we(req_we_s[0]),
    .req_addr(req_addr_s[0]), .req_wdata(req_wdata_s[0]),
    .req_ready(req_ready_s[0]), .rsp_valid(rsp_valid_s[0]),
    .rsp_rdata(rsp_rdata_s[0]), .rsp_err(rsp_err_s[0]), .busy(busy_s[0]),
    .bram_rd_enable(rd_en_s[0]), .bram_wr_enable(wr_en_s[0]),
    .bram_addr(bram_addr_s[0]), .bram_wr_data(bram_wd_s[0]),
    .bram_rd_data(pipe_m[0][0])
  );

  memc_multiport #(.NUM_PORTS(NP), .DATA_WIDTH(8), .ADDR_WIDTH(16),
                   .MEM_DEPTH(65536), .RD_LATENCY(3)) u_dut1 (
    .clk(clk), .reset(rst_n[1]),
    .req_valid(req_valid_s[1]), .req_we(req_we_s[1]),
    .req_addr(req_addr_s[1]), .req_wdata(req_wdata_s[1]),
    .req_ready(req_ready_s[1]), .rsp_valid(rsp_valid_s[1]),
    .rsp_rdata(rsp_rdata_s[1]), .rsp_err(rsp_err_s[1]), .busy(busy_s[1]),
    .bram_rd_enable(rd_en_s[1]), .bram_wr_enable(wr_en_s[1]),
    .bram_addr(bram_addr_s[1]), .bram_wr_data(bram_wd_s[1]),
    .bram_rd_data(pipe_m[1][2])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int depth_of(input int k);
    return (k == 0) ? 1024 : 65536;
  endfunction

  always #5 clk = ~clk;

  // Cycle counter, incremented on every rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Block RAM model: synchronous write, read data appears RD_LATENCY cycles after the strobe.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (wr_en_s[k] === 1'b1) ram_m[k][bram_addr_s[k]] <= bram_wd_s[k];
      pipe_m[k][0] <= (rd_en_s[k] === 1'b1) ? ram_m[k][bram_addr_s[k]] : 8'hEE;
      for (int j = 1; j < 4; j++) pipe_m[k][j] <= pipe_m[k][j-1];
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic clear_slots(input int k);
    str_cyc[k]   = -1;
    str_rd[k]    = 1'b0;
    str_wr[k]    = 1'b0;
    str_addr[k]  = 16'h0000;
    str_wd[k]    = 8'h00;
    busy_from[k] = 1;
    busy_to[k]   = 0;
    last_rd[k]   = 8'h00;
  endtask

  task automatic mon_step(input int k);
    logic er, ew, eb, w, inr;
    logic [NP-1:0] hs;
    logic [15:0] a;
    logic [7:0] d;
    int g;
    exp_t e;
    er = (str_cyc[k] == cyc) && str_rd[k];
    ew = (str_cyc[k] == cyc) && str_wr[k];
    if (er || ew || (rd_en_s[k] !== 1'b0) || (wr_en_s[k] !== 1'b0)) begin
      chk_eq("bram_rd_enable", 32'(rd_en_s[k]), 32'(er));
      chk_eq("bram_wr_enable", 32'(wr_en_s[k]), 32'(ew));
      chk_eq("bram_addr", 32'(bram_addr_s[k]), 32'(str_addr[k]));
      if (ew) chk_eq("bram_wr_data", 32'(bram_wd_s[k]), 32'(str_wd[k]));
    end
    eb = (cyc >= busy_from[k]) && (cyc <= busy_to[k]);
    chk_eq("busy", 32'(busy_s[k]), 32'(eb));
    chk_eq("ready_without_valid", 32'(req_ready_s[k] & ~req_valid_s[k]), 32'd0);
    if (req_ready_s[k] != '0) begin
      chk_eq("ready_onehot", 32'($countones(req_ready_s[k])), 32'd1);
      chk_eq("ready_while_busy", 32'(eb), 32'd0);
    end
    if (rsp_valid_s[k] !== '0) begin
      if (sb_q.size() == 0) begin
        chk_eq("rsp_unexpected", 32'(rsp_valid_s[k]), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk_eq("rsp_inst", 32'(k), 32'(e.inst));
        chk_eq("rsp_cycle", 32'(cyc), 32'(e.due));
        chk_eq("rsp_valid", 32'(rsp_valid_s[k]), 32'd1 << e.port);
        chk_eq("rsp_err", 32'(rsp_err_s[k]), 32'(e.err));
        chk_eq("rsp_rdata", 32'(rsp_rdata_s[k]), 32'(e.rdata));
      end
    end else if (sb_q.size() != 0 && sb_q[0].inst == k && sb_q[0].due < cyc) begin
      e = sb_q.pop_front();
      chk_eq("rsp_missing", 32'd0, 32'd1 << e.port);
    end
    hs = req_valid_s[k] & req_ready_s[k];
    if (hs != '0) begin
      g = 0;
      for (int p = NP - 1; p >= 0; p--) if (hs[p]) g = p;
      grant_log.push_back(g);
      a   = req_addr_s[k][g*16 +: 16];
      d   = req_wdata_s[k][g*8 +: 8];
      w   = req_we_s[k][g];
      inr = (int'(a) < depth_of(k));
      e.inst = k;
      e.port = g;
      e.err  = !inr;
      e.due  = cyc + (w ? 2 : 2 + lat_of(k));
      if (w) begin
        e.rdata = last_rd[k];
        if (inr) ref_m[k][a] = d;
      end else begin
        e.rdata    = inr ? ref_m[k][a] : 8'h00;
        last_rd[k] = e.rdata;
      end
      sb_q.push_back(e);
      str_cyc[k]   = cyc + 1;
      str_rd[k]    = !w && inr;
      str_wr[k]    = w && inr;
      str_addr[k]  = a;
      str_wd[k]    = d;
      busy_from[k] = cyc + 1;
      busy_to[k]   = e.due;
    end
  endtask

  // Monitor: sample both instances on the falling edge while out of reset.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) if (rst_n[k] === 1'b1) mon_step(k);
    end
  end

  task automatic zero_chk(input int k);
    chk_eq("rst_req_ready", 32'(req_ready_s[k]), 32'd0);
    chk_eq("rst_rsp_valid", 32'(rsp_valid_s[k]), 32'd0);
    chk_eq("rst_rsp_rdata", 32'(rsp_rdata_s[k]), 32'd0);
    chk_eq("rst_rsp_err", 32'(rsp_err_s[k]), 32'd0);
    chk_eq("rst_busy", 32'(busy_s[k]), 32'd0);
    chk_eq("rst_rd_en", 32'(rd_en_s[k]), 32'd0);
    chk_eq("rst_wr_en", 32'(wr_en_s[k]), 32'd0);
    chk_eq("rst_bram_addr", 32'(bram_addr_s[k]), 32'd0);
    chk_eq("rst_bram_wr_data", 32'(bram_wd_s[k]), 32'd0);
  endtask

  // Present one request, wait for the grant, then leave time for the response.
  task automatic send(input int k, input int p, input logic w,
                      input logic [15:0] a, input logic [7:0] d);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    req_we_s[k][p]            = w;
    req_addr_s[k][p*16 +: 16] = a;
    req_wdata_s[k][p*8 +: 8]  = d;
    req_valid_s[k][p]         = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = req_ready_s[k][p];
    end
    chk_eq("handshake", 32'(got), 32'd1);
    @(posedge clk); #1;
    req_valid_s[k][p] = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  // Ports in mask hold reads until n grants are seen; grant order checked against exp nibbles.
  task automatic contend(input int k, input logic [NP-1:0] mask, input int n,
                         input logic [31:0] exp);
    grant_log.delete();
    @(posedge clk); #1;
    for (int p = 0; p < NP; p++) begin
      if (mask[p]) begin
        req_we_s[k][p]            = 1'b0;
        req_addr_s[k][p*16 +: 16] = 16'h0200;
        req_valid_s[k][p]         = 1'b1;
      end
    end
    for (int i = 0; i < 200 && grant_log.size() < n; i++) begin
      @(posedge clk); #1;
    end
    req_valid_s[k] = '0;
    chk_eq("grant_count", 32'(grant_log.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      chk_eq("grant_order", (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hFFFF_FFFF,
             32'(exp[i*4 +: 4]));
    end
    repeat (10) @(posedge clk);
  endtask

  initial begin
    logic got;
    for (int k = 0; k < NI; k++) begin
      rst_n[k]       = 1'b0;
      req_valid_s[k] = '0;
      req_we_s[k]    = '0;
      req_addr_s[k]  = '0;
      req_wdata_s[k] = '0;
      clear_slots(k);
    end
    req_valid_s[0] = 4'b0001;
    repeat (2) @(posedge clk); #1;
    zero_chk(0);
    zero_chk(1);
    req_valid_s[0] = '0;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    repeat (2) @(posedge clk);

    // Instance 0, RD_LATENCY=1, MEM_DEPTH=1024
    send(0, 0, 1'b1, 16'h0200, 8'hA5);
    send(0, 1, 1'b0, 16'h0200, 8'h00);
    send(0, 2, 1'b1, 16'h03FF, 8'h5C);
    send(0, 3, 1'b0, 16'h03FF, 8'h00);
    contend(0, 4'b0011, 6, 32'h0010_1010);
    send(0, 0, 1'b0, 16'h0400, 8'h00);
    send(0, 1, 1'b1, 16'h0400, 8'h77);
    chk_eq("oor_write_ram", 32'(ram_m[0][16'h0400]), 32'd0);
    send(0, 0, 1'b0, 16'h0200, 8'h00);

    // Reset while a read on port 0 sits in WAIT
    got = 1'b0;
    @(posedge clk); #1;
    req_we_s[0][0]         = 1'b0;
    req_addr_s[0][15:0]    = 16'h0200;
    req_valid_s[0][0]      = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = req_ready_s[0][0];
    end
    chk_eq("mid_handshake", 32'(got), 32'd1);
    @(posedge clk); #1;
    req_valid_s[0][0] = 1'b0;
    @(posedge clk); #1;
    chk_eq("pre_reset_busy", 32'(busy_s[0]), 32'd1);
    rst_n[0] = 1'b0;
    sb_q.delete();
    clear_slots(0);
    #1;
    zero_chk(0);
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    repeat (8) @(posedge clk);
    contend(0, 4'b0011, 2, 32'h0000_0010);

    // Instance 1, RD_LATENCY=3, four ports
    send(1, 0, 1'b1, 16'h0200, 8'hA5);
    send(1, 1, 1'b0, 16'h0200, 8'h00);
    send(1, 2, 1'b1, 16'hFFFF, 8'h3C);
    send(1, 3, 1'b0, 16'hFFFF, 8'h00);
    contend(1, 4'b1010, 4, 32'h0000_3131);

    chk_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
